// File: rtl/stopwatch_timebase.sv
// -----------------------------------------------------------------------------
// stopwatch_timebase
//
// Counting datapath behind the stopwatch run/pause/clear FSM. The FSM decodes
// are registered into a mode, and a prescaler produces one count step every
// DIV clocks while running. Each step advances a 4-digit packed-BCD elapsed
// time by 1 (ONE mode) or by 10 (TEN mode). The count saturates at MAX_BCD
// and raises a sticky overflow flag. The display value goes to the
// seven-segment mux.
//
// Parameters
//   DIV      clock cycles per count step (>= 2); prescaler is $clog2(DIV) bits
//   MAX_BCD  saturation ceiling as packed BCD; every nibble must be 0-9
//
// Ports
//   clk           in   system clock
//   rst           in   asynchronous active-high reset
//   clear_push    in   FSM is in CLEAR
//   pause_push    in   FSM is in PAUSE
//   one_run_push  in   FSM is in ones-run
//   ten_run_push  in   FSM is in tens-run
//   lap           in   lap button, one-cycle synchronized pulse
//   digits  [15:0] out  displayed BCD value {d3,d2,d1,d0}
//   tick          out  high in the first cycle a new count value is visible
//   ovf           out  sticky saturation flag, cleared only in IDLE
//   mode    [1:0] out  registered mode: 0 IDLE, 1 ONE, 2 TEN, 3 HOLD
//   frozen        out  lap freeze active
//
// Build option
//   STOPWATCH_LAP_EN  when defined, a lap pulse while running toggles a
//                     display freeze. When undefined, lap is ignored,
//                     frozen is 0 and digits always shows the live count.
// -----------------------------------------------------------------------------
module stopwatch_timebase #(
    parameter int unsigned DIV     = 10,
    parameter logic [15:0] MAX_BCD = 16'h9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_push,
    input  logic        pause_push,
    input  logic        one_run_push,
    input  logic        ten_run_push,
    input  logic        lap,
    output logic [15:0] digits,
    output logic        tick,
    output logic        ovf,
    output logic [1:0]  mode,
    output logic        frozen
);

    localparam int unsigned     PSC_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(DIV - 1);

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_ONE  = 2'd1,
        MODE_TEN  = 2'd2,
        MODE_HOLD = 2'd3
    } mode_e;

    // Priority clear > pause > ten > one; nothing asserted parks the counter.
    function automatic mode_e decode_mode(input logic c, input logic p,
                                          input logic t, input logic o);
        mode_e m;
        if (c)      m = MODE_IDLE;
        else if (p) m = MODE_HOLD;
        else if (t) m = MODE_TEN;
        else if (o) m = MODE_ONE;
        else        m = MODE_HOLD;
        return m;
    endfunction

    // Decimal increment of the packed BCD value. In tens mode the units digit
    // is skipped, so the +1 enters at d1. Bit 16 of the result is the carry
    // out of d3.
    function automatic logic [16:0] bcd_step(input logic [15:0] v, input logic tens);
        logic [15:0] r;
        logic        c;
        logic [3:0]  nib;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (!(tens && (i == 0))) begin
                nib = v[i*4 +: 4];
                if (c) begin
                    if (nib >= 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                        c           = 1'b1;
                    end else begin
                        r[i*4 +: 4] = nib + 4'd1;
                        c           = 1'b0;
                    end
                end
            end
        end
        return {c, r};
    endfunction

    // Clamp a step result to MAX_BCD. Bit 16 of the return flags the clamp.
    // Packed BCD with valid nibbles orders the same as its binary reading,
    // so a plain unsigned compare is enough.
    function automatic logic [16:0] saturate(input logic [16:0] sum);
        logic [16:0] r;
        if (sum[16] || (sum[15:0] > MAX_BCD)) r = {1'b1, MAX_BCD};
        else                                  r = {1'b0, sum[15:0]};
        return r;
    endfunction

    mode_e             mode_q,  mode_d;
    logic [PSC_W-1:0]  psc_q,   psc_d;
    logic [15:0]       count_q, count_d;
    logic              tick_q,  tick_d;
    logic              ovf_q,   ovf_d;

    logic              running;
    logic              step_en;
    logic [16:0]       step_sum;
    logic [16:0]       step_sat;

    assign running  = (mode_q == MODE_ONE) || (mode_q == MODE_TEN);
    assign step_en  = running && (psc_q == PSC_LAST);
    assign step_sum = bcd_step(count_q, mode_q == MODE_TEN);
    assign step_sat = saturate(step_sum);

    always_comb begin
        mode_d  = decode_mode(clear_push, pause_push, ten_run_push, one_run_push);
        psc_d   = psc_q;
        count_d = count_q;
        tick_d  = 1'b0;
        ovf_d   = ovf_q;
        case (mode_q)
            MODE_IDLE: begin
                psc_d   = '0;
                count_d = '0;
                ovf_d   = 1'b0;
            end
            MODE_ONE, MODE_TEN: begin
                // Switching between ONE and TEN keeps the prescaler phase.
                psc_d = (psc_q == PSC_LAST) ? '0 : psc_q + 1'b1;
                if (step_en) begin
                    count_d = step_sat[15:0];
                    ovf_d   = ovf_q | step_sat[16];
                    tick_d  = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= MODE_IDLE;
            psc_q   <= '0;
            count_q <= '0;
            tick_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            psc_q   <= psc_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            ovf_q   <= ovf_d;
        end
    end

    assign mode = mode_q;
    assign tick = tick_q;
    assign ovf  = ovf_q;

`ifdef STOPWATCH_LAP_EN
    logic        frozen_q, frozen_d;
    logic [15:0] lap_q,    lap_d;

    // The captured value is the count on display when lap arrives, even if
    // a step lands on the same edge.
    always_comb begin
        frozen_d = frozen_q;
        lap_d    = lap_q;
        if (mode_q == MODE_IDLE) begin
            frozen_d = 1'b0;
            lap_d    = '0;
        end else if (running && lap) begin
            frozen_d = ~frozen_q;
            if (!frozen_q) lap_d = count_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frozen_q <= 1'b0;
            lap_q    <= '0;
        end else begin
            frozen_q <= frozen_d;
            lap_q    <= lap_d;
        end
    end

    assign frozen = frozen_q;
    assign digits = frozen_q ? lap_q : count_q;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign frozen     = 1'b0;
    assign digits     = count_q;
`endif

endmodule
